mem_access_unit: RTL and testbench

- Load/store front-end sitting directly upstream of the word-wide data RAM (clk/we/addr/d_in/d_out; asynchronous read, write on rising clk when we=1).
- Takes MIPS load/store requests from the core: byte, halfword and word, signed or unsigned.
- Drives RAM ports; sub-word stores are done as read-modify-write; loads are extracted and sign/zero-extended.
- Flags misaligned and illegal-size accesses without touching memory.

---
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS load/store front-end for a word-wide asynchronous-read data RAM
// Sub-word stores are read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
   parameter bit WORD_ADDR = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic        r_we, r_signed, r_err;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_wdata, buf_q;
   logic [31:0] mem_addr_q, mem_wdata_q, resp_rdata_q;
   logic        resp_err_q;
   logic        req_err;
   logic [31:0] addr_now, wdata_now, rdata_now;

   function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] lo,
                                                input logic [1:0] sz, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lo, 3'b000} +: 8];
      h = lo[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   return {{24{sgn & b[7]}}, b};
         2'b01:   return {{16{sgn & h[15]}}, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] lo, input logic [1:0] sz);
      logic [31:0] m;
      m = w;
      case (sz)
         2'b00: m[{lo, 3'b000} +: 8] = d[7:0];
         2'b01: if (lo[1]) m[31:16] = d[15:0]; else m[15:0] = d[15:0];
         default: m = d;
      endcase
      return m;
   endfunction

   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   assign addr_now  = WORD_ADDR ? {2'b00, r_addr[31:2]} : {r_addr[31:2], 2'b00};
   assign wdata_now = (r_size == 2'b10) ? r_wdata : merge_lane(buf_q, r_wdata, r_addr[1:0], r_size);
   assign rdata_now = (!r_we && !r_err) ? extract_lane(buf_q, r_addr[1:0], r_size, r_signed) : 32'h0;

   // Live values are shown while a state owns them; otherwise the last value is held.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign mem_we     = (state_q == WRITE) && rst_n;
   assign mem_addr   = (state_q == READ || state_q == WRITE) ? addr_now : mem_addr_q;
   assign mem_wdata  = (state_q == WRITE) ? wdata_now : mem_wdata_q;
   assign resp_rdata = (state_q == RESP) ? rdata_now : resp_rdata_q;
   assign resp_err   = (state_q == RESP) ? r_err : resp_err_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err)                           state_d = RESP;
               else if (req_we && req_size == 2'b10)  state_d = WRITE;
               else                                   state_d = READ;
            end
         end
         READ:    state_d = r_we ? WRITE : RESP;
         WRITE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         r_we         <= 1'b0;
         r_signed     <= 1'b0;
         r_err        <= 1'b0;
         r_size       <= 2'b00;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         buf_q        <= 32'h0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_signed <= req_signed;
                  r_err    <= req_err;
                  r_size   <= req_size;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
               end
            end
            READ:  begin
               buf_q      <= mem_rdata;
               mem_addr_q <= addr_now;
            end
            WRITE: begin
               mem_addr_q  <= addr_now;
               mem_wdata_q <= wdata_now;
            end
            default: begin
               resp_rdata_q <= rdata_now;
               resp_err_q   <= r_err;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// A 16-word RAM model sits on the memory port; outputs are sampled on the falling edge.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] ram [0:15];

   int tests = 0;
   int fails = 0;

   int          o_lat, o_we_cnt, o_we_lat;
   logic [31:0] o_rdata, o_we_addr, o_we_wdata;
   logic        o_err, o_we_c1;

   mem_access_unit #(.WORD_ADDR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr[3:0]];
   always @(posedge clk) if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;

   task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      o_lat = 0; o_we_cnt = 0; o_we_lat = 0; o_we_c1 = mem_we;
      o_rdata = 32'hDEAD_BEEF; o_err = 1'bx; o_we_addr = 32'hx; o_we_wdata = 32'hx;
      for (int n = 1; n <= 8; n++) begin
         if (mem_we) begin
            o_we_cnt++; o_we_lat = n; o_we_addr = mem_addr; o_we_wdata = mem_wdata;
         end
         if (resp_valid) begin
            o_lat = n; o_rdata = resp_rdata; o_err = resp_err;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
      tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", resp_err); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
   endtask

   task automatic test_word_store();
      run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h4321_4312);
      tests++; if (o_we_lat !== 1) begin fails++; $display("FAIL sw_we_cycle got %0d want 1", o_we_lat); end
      tests++; if (o_we_cnt !== 1) begin fails++; $display("FAIL sw_we_count got %0d want 1", o_we_cnt); end
      tests++; if (o_we_addr !== 32'h1) begin fails++; $display("FAIL sw_mem_addr got %h want 00000001", o_we_addr); end
      tests++; if (o_we_wdata !== 32'h4321_4312) begin fails++; $display("FAIL sw_mem_wdata got %h want 43214312", o_we_wdata); end
      tests++; if (o_lat !== 2) begin fails++; $display("FAIL sw_latency got %0d want 2", o_lat); end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL sw_err got %b want 0", o_err); end
      tests++; if (ram[1] !== 32'h4321_4312) begin fails++; $display("FAIL sw_ram got %h want 43214312", ram[1]); end
   endtask

   task automatic test_loads();
      logic [1:0]  sz  [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
      logic        sg  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] ad  [5] = '{32'h8, 32'hA, 32'hA, 32'h9, 32'hA};
      logic [31:0] exp [5] = '{32'h80FF_7F01, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_007F, 32'hFFFF_80FF};
      run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h80FF_7F01);
      for (int i = 0; i < 5; i++) begin
         run_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
         tests++; if (o_rdata !== exp[i]) begin fails++; $display("FAIL load_%0d_data got %h want %h", i, o_rdata, exp[i]); end
         tests++; if (o_lat !== 2) begin fails++; $display("FAIL load_%0d_latency got %0d want 2", i, o_lat); end
      end
      run_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
      tests++; if (o_rdata !== 32'h0000_80FF) begin fails++; $display("FAIL lhu_data got %h want 000080ff", o_rdata); end
      tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL load_no_write got %0d want 0", o_we_cnt); end
   endtask

   task automatic test_subword_store();
      run_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AB);
      tests++; if (o_we_c1 !== 1'b0) begin fails++; $display("FAIL sb_read_we got %b want 0", o_we_c1); end
      tests++; if (o_we_lat !== 2) begin fails++; $display("FAIL sb_we_cycle got %0d want 2", o_we_lat); end
      tests++; if (o_we_wdata !== 32'h43AB_4312) begin fails++; $display("FAIL sb_wdata got %h want 43ab4312", o_we_wdata); end
      tests++; if (o_lat !== 3) begin fails++; $display("FAIL sb_latency got %0d want 3", o_lat); end
      run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      tests++; if (o_rdata !== 32'h43AB_4312) begin fails++; $display("FAIL sb_readback got %h want 43ab4312", o_rdata); end
      run_req(1'b1, 2'b01, 1'b0, 32'h4, 32'h0000_BEEF);
      tests++; if (o_we_wdata !== 32'h43AB_BEEF) begin fails++; $display("FAIL sh_wdata got %h want 43abbeef", o_we_wdata); end
      tests++; if (o_lat !== 3) begin fails++; $display("FAIL sh_latency got %0d want 3", o_lat); end
   endtask

   task automatic test_errors();
      logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] ad [3] = '{32'h6, 32'h5, 32'h4};
      for (int i = 0; i < 3; i++) begin
         run_req(1'b0, sz[i], 1'b0, ad[i], 32'h0);
         tests++; if (o_lat !== 1) begin fails++; $display("FAIL err_%0d_latency got %0d want 1", i, o_lat); end
         tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL err_%0d_flag got %b want 1", i, o_err); end
         tests++; if (o_rdata !== 32'h0) begin fails++; $display("FAIL err_%0d_rdata got %h want 0", i, o_rdata); end
         tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL err_%0d_we got %0d want 0", i, o_we_cnt); end
      end
      run_req(1'b1, 2'b01, 1'b0, 32'h7, 32'h1234_5678);
      tests++; if (o_we_cnt !== 0 || o_err !== 1'b1) begin fails++; $display("FAIL err_store got we=%0d err=%b want 0 1", o_we_cnt, o_err); end
      tests++; if (ram[1] !== 32'h43AB_BEEF) begin fails++; $display("FAIL err_store_ram got %h want 43abbeef", ram[1]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ad  [3] = '{32'h4, 32'h8, 32'h0};
      logic [31:0] exp [3] = '{32'h43AB_BEEF, 32'h80FF_7F01, 32'h0};
      int acc = 0;
      int rc = 0;
      int rcyc [3] = '{0, 0, 0};
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (resp_valid) begin
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_in_resp got %b want 0", req_ready); end
            if (rc < 3) begin
               tests++; if (resp_rdata !== exp[rc]) begin fails++; $display("FAIL b2b_data_%0d got %h want %h", rc, resp_rdata, exp[rc]); end
               rcyc[rc] = c;
            end
            rc++;
         end
         if (req_ready) begin
            if (acc < 3) begin req_valid = 1'b1; req_addr = ad[acc]; acc++; end
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      tests++; if (rc !== 3) begin fails++; $display("FAIL b2b_resp_count got %0d want 3", rc); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (rcyc[i] !== 3 * i + 2) begin fails++; $display("FAIL b2b_resp_cycle_%0d got %0d want %0d", i, rcyc[i], 3 * i + 2); end
      end
   endtask

   task automatic test_reset_in_write();
      run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h4321_4312);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h6; req_wdata = 32'hAB;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL rstw_write_cycle got %b want 1", mem_we); end
      rst_n = 1'b0;
      #1;
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rstw_we_suppressed got %b want 0", mem_we); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tests++; if (ram[1] !== 32'h4321_4312) begin fails++; $display("FAIL rstw_ram got %h want 43214312", ram[1]); end
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rstw_resp_valid got %b want 0", resp_valid); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstw_ready got %b want 1", req_ready); end
      @(negedge clk);
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rstw_no_late_resp got %b want 0", resp_valid); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_word_store();
      test_loads();
      test_subword_store();
      test_errors();
      test_back_to_back();
      test_reset_in_write();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
